// File: rtl/ff_resp_checker.sv
// ff_resp_checker: scoreboard for a single D flop.
// Predicts q from d/rst LATENCY cycles back and counts compares and errors.
module ff_resp_checker #(
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned CNT_W       = 8,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             dut_rst,
  input  logic             d_obs,
  input  logic             q_obs,
  output logic             mismatch,
  output logic             fail,
  output logic             pass,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } st_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  st_t cur;
  st_t nxt;

  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0] pvld;
  logic               last_v;
  logic               exp_v;
  logic               cmp;
  logic               miss;

  assign last_v = pvld[LATENCY-1];
  assign exp_v  = pv[LATENCY-1];

  // A compare needs an active checker, CHECK state and a valid oldest stage.
  assign cmp  = en && (cur == CHECK) && last_v;
  assign miss = cmp && (q_obs != exp_v);

  // Expected-value pipeline: values carry no reset, they are only
  // meaningful when the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (en) begin
      pv[0] <= dut_rst ? 1'b0 : d_obs;
      for (int k = 1; k < int'(LATENCY); k++) begin
        pv[k] <= pv[k-1];
      end
    end
  end

  // Valid bits: cleared on reset, clear or whenever the checker is idle.
  always_ff @(posedge clk) begin
    if (!reset || clear || !en) begin
      pvld <= '0;
    end else begin
      pvld[0] <= 1'b1;
      for (int k = 1; k < int'(LATENCY); k++) begin
        pvld[k] <= pvld[k-1];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur <= IDLE;
    end else if (clear) begin
      cur <= IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // Next-state logic; HALT is left only through clear or reset.
  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE: begin
        if (en) nxt = FILL;
      end
      FILL: begin
        if (!en) nxt = IDLE;
        else if (last_v) nxt = CHECK;
      end
      CHECK: begin
        if (!en) nxt = IDLE;
        else if (miss && STOP_ON_ERR) nxt = HALT;
      end
      HALT: begin
        nxt = HALT;
      end
      default: nxt = IDLE;
    endcase
  end

  // Counters, sticky fail and the registered mismatch pulse.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      chk_cnt  <= '0;
      err_cnt  <= '0;
      fail     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      mismatch <= miss;
      if (cmp && (chk_cnt != MAX)) begin
        chk_cnt <= chk_cnt + ONE;
      end
      if (miss) begin
        fail <= 1'b1;
        if (err_cnt != MAX) begin
          err_cnt <= err_cnt + ONE;
        end
      end
    end
  end

  assign pass  = (chk_cnt != '0) && !fail;
  assign state = cur;

endmodule

// File: tb/tb_ff_resp_checker.sv
// tb_ff_resp_checker: directed scoreboard bench for ff_resp_checker.
// Four instances: default, stop-on-error, latency 3, 2-bit counters.
module tb_ff_resp_checker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic clear = 1'b0;
  logic dut_rst = 1'b0;
  logic d_obs = 1'b0;
  logic q_obs = 1'b0;
  logic q3 = 1'b0;

  logic [1:0] st0, st1, st2, st3;
  logic [7:0] c0, c1, c2, e0, e1, e2;
  logic [1:0] c3, e3;
  logic m0, m1, m2, m3;
  logic f0, f1, f2, f3;
  logic p0, p1, p2, p3;

  typedef struct {
    int    cyc;
    int    inst;
    int    sig;
    int    val;
    string nm;
  } item_t;

  item_t sb[$];
  int    mq[$];
  int    cyc = 0;
  int    nchk = 0;
  int    nfail = 0;
  bit    hv[3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  ff_resp_checker #(.LATENCY(1), .CNT_W(8), .STOP_ON_ERR(1'b0)) u0 (
    .clk(clk), .reset(reset), .en(en), .clear(clear),
    .dut_rst(dut_rst), .d_obs(d_obs), .q_obs(q_obs),
    .mismatch(m0), .fail(f0), .pass(p0),
    .chk_cnt(c0), .err_cnt(e0), .state(st0));

  ff_resp_checker #(.LATENCY(1), .CNT_W(8), .STOP_ON_ERR(1'b1)) u1 (
    .clk(clk), .reset(reset), .en(en), .clear(clear),
    .dut_rst(dut_rst), .d_obs(d_obs), .q_obs(q_obs),
    .mismatch(m1), .fail(f1), .pass(p1),
    .chk_cnt(c1), .err_cnt(e1), .state(st1));

  ff_resp_checker #(.LATENCY(3), .CNT_W(8), .STOP_ON_ERR(1'b0)) u2 (
    .clk(clk), .reset(reset), .en(en), .clear(clear),
    .dut_rst(dut_rst), .d_obs(d_obs), .q_obs(q3),
    .mismatch(m2), .fail(f2), .pass(p2),
    .chk_cnt(c2), .err_cnt(e2), .state(st2));

  ff_resp_checker #(.LATENCY(1), .CNT_W(2), .STOP_ON_ERR(1'b0)) u3 (
    .clk(clk), .reset(reset), .en(en), .clear(clear),
    .dut_rst(dut_rst), .d_obs(d_obs), .q_obs(q_obs),
    .mismatch(m3), .fail(f3), .pass(p3),
    .chk_cnt(c3), .err_cnt(e3), .state(st3));

  // sig: 0 state, 1 chk_cnt, 2 err_cnt, 3 fail, 4 pass, 5 mismatch
  function automatic int getv(int i, int s);
    logic [7:0] a[6];
    case (i)
      0: a = '{8'(st0), c0, e0, 8'(f0), 8'(p0), 8'(m0)};
      1: a = '{8'(st1), c1, e1, 8'(f1), 8'(p1), 8'(m1)};
      2: a = '{8'(st2), c2, e2, 8'(f2), 8'(p2), 8'(m2)};
      default: a = '{8'(st3), 8'(c3), 8'(e3), 8'(f3), 8'(p3), 8'(m3)};
    endcase
    return int'(a[s]);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations due this cycle and checks mismatch pulses.
  always @(negedge clk) begin
    item_t it;
    int act;
    int e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      act = getv(it.inst, it.sig);
      nchk++;
      if (act != it.val) begin
        nfail++;
        $display("FAIL %s u%0d cyc %0d: got %0d want %0d",
                 it.nm, it.inst, cyc, act, it.val);
      end
    end
    if (m0) begin
      nchk++;
      if (mq.size() == 0) begin
        nfail++;
        $display("FAIL mismatch_unexp u0 cyc %0d: got 1 want 0", cyc);
      end else begin
        e = mq.pop_front();
        if (e != cyc) begin
          nfail++;
          $display("FAIL mismatch_cyc u0: got cyc %0d want cyc %0d",
                   cyc, e);
        end
      end
    end
    while (mq.size() > 0 && mq[0] < cyc) begin
      e = mq.pop_front();
      nchk++;
      nfail++;
      $display("FAIL mismatch_missing u0 cyc %0d: got 0 want 1", e);
    end
  end

  task automatic drv(input bit rn, input bit cl, input bit e,
                     input bit r, input bit d, input bit inj);
    @(posedge clk);
    #1;
    reset   = rn;
    clear   = cl;
    en      = e;
    dut_rst = r;
    d_obs   = d;
    q_obs   = hv[0] ^ inj;
    q3      = hv[2];
    hv[2]   = hv[1];
    hv[1]   = hv[0];
    hv[0]   = r ? 1'b0 : d;
  endtask

  // Expectation on the outputs once the inputs just driven are sampled.
  task automatic ex(input int i, input int s, input int v, input string nm);
    sb.push_back('{cyc + 1, i, s, v, nm});
  endtask

  task automatic mx();
    mq.push_back(cyc + 1);
  endtask

  initial begin
    // Reset, then a correct flop model with d = 1,0,1,1,0,0
    drv(0, 0, 0, 0, 0, 0);
    ex(0, 0, 0, "rst_state"); ex(0, 1, 0, "rst_chk");
    ex(0, 2, 0, "rst_err");   ex(0, 3, 0, "rst_fail");
    ex(0, 4, 0, "rst_pass");  ex(0, 5, 0, "rst_mis");
    drv(1, 0, 1, 0, 1, 0);
    ex(0, 0, 1, "fill");  ex(2, 0, 1, "l3_fill1");
    drv(1, 0, 1, 0, 0, 0);
    ex(0, 0, 2, "check"); ex(0, 1, 0, "fill_nochk");
    ex(2, 0, 1, "l3_fill2");
    drv(1, 0, 1, 0, 1, 0);
    ex(0, 1, 1, "chk1");  ex(2, 0, 1, "l3_fill3");
    drv(1, 0, 1, 0, 1, 0);
    ex(2, 0, 2, "l3_check"); ex(2, 1, 0, "l3_nochk");
    drv(1, 0, 1, 0, 0, 0);
    ex(2, 1, 1, "l3_chk1");
    drv(1, 0, 1, 0, 0, 0);
    ex(0, 1, 4, "chk4");  ex(0, 2, 0, "err0");
    ex(0, 4, 1, "pass1"); ex(0, 3, 0, "fail0");
    ex(2, 1, 2, "l3_chk2");

    // Three forced mismatches; u1 halts on the first
    drv(1, 0, 1, 0, 1, 0);
    ex(0, 1, 5, "chk5");
    drv(1, 0, 1, 0, 1, 1); mx();
    ex(1, 0, 3, "halt"); ex(1, 2, 1, "halt_err");
    ex(1, 5, 1, "halt_mis"); ex(1, 1, 6, "halt_chk");
    drv(1, 0, 1, 0, 1, 1); mx();
    ex(1, 5, 0, "halt_mis_pulse"); ex(1, 1, 6, "halt_chk_frz");
    drv(1, 0, 1, 0, 0, 1); mx();
    ex(0, 2, 3, "err3"); ex(0, 3, 1, "fail1");
    ex(0, 4, 0, "pass0"); ex(0, 1, 8, "chk8");
    drv(1, 0, 1, 0, 0, 0);
    ex(0, 1, 9, "chk9"); ex(0, 2, 3, "err_hold");
    ex(1, 0, 3, "halt_hold"); ex(1, 1, 6, "halt_chk_hold");
    ex(1, 2, 1, "halt_err_hold"); ex(1, 3, 1, "halt_fail");

    // Clear while en=1
    drv(1, 1, 1, 0, 0, 0);
    ex(0, 0, 0, "clr_state"); ex(0, 1, 0, "clr_chk");
    ex(0, 2, 0, "clr_err");   ex(0, 3, 0, "clr_fail");
    ex(1, 0, 0, "clr_halt");  ex(1, 1, 0, "clr_halt_chk");
    ex(1, 2, 0, "clr_halt_err");

    // dut_rst forces expected 0
    drv(1, 0, 1, 0, 0, 0);
    drv(1, 0, 1, 1, 1, 0);
    ex(0, 0, 2, "dr_check");
    drv(1, 0, 1, 1, 1, 0);
    ex(0, 1, 1, "dr_chk1"); ex(0, 2, 0, "dr_ok");
    drv(1, 0, 1, 1, 1, 1); mx();
    ex(0, 1, 2, "dr_chk2"); ex(0, 2, 1, "dr_err1");
    ex(0, 3, 1, "dr_fail");

    // Drop en mid-check: counters hold
    drv(1, 0, 0, 0, 0, 0);
    ex(0, 0, 0, "drop_idle"); ex(0, 1, 2, "drop_chk");
    ex(0, 2, 1, "drop_err");  ex(0, 3, 1, "drop_fail");
    drv(1, 0, 0, 0, 0, 0);
    ex(0, 1, 2, "drop_chk_hold");

    // LATENCY=3: three FILL cycles, drop and re-enter
    drv(1, 1, 0, 0, 0, 0);
    drv(1, 0, 1, 0, 1, 0); ex(2, 0, 1, "l3b_fill1");
    drv(1, 0, 1, 0, 0, 0); ex(2, 0, 1, "l3b_fill2");
    drv(1, 0, 1, 0, 1, 0); ex(2, 0, 1, "l3b_fill3");
    drv(1, 0, 1, 0, 1, 0);
    ex(2, 0, 2, "l3b_check"); ex(2, 1, 0, "l3b_nochk");
    drv(1, 0, 1, 0, 0, 0); ex(2, 1, 1, "l3b_chk1");
    drv(1, 0, 1, 0, 0, 0); ex(2, 1, 2, "l3b_chk2");
    drv(1, 0, 0, 0, 0, 0);
    ex(2, 0, 0, "l3b_idle"); ex(2, 1, 2, "l3b_hold");
    drv(1, 0, 0, 0, 0, 0); ex(2, 1, 2, "l3b_hold2");
    drv(1, 0, 1, 0, 1, 0); ex(2, 0, 1, "l3c_fill1");
    drv(1, 0, 1, 0, 1, 0); ex(2, 0, 1, "l3c_fill2");
    drv(1, 0, 1, 0, 1, 0); ex(2, 0, 1, "l3c_fill3");
    drv(1, 0, 1, 0, 0, 0);
    ex(2, 0, 2, "l3c_check"); ex(2, 1, 2, "l3c_nochk");
    drv(1, 0, 1, 0, 0, 0);
    ex(2, 1, 3, "l3c_chk3"); ex(2, 2, 0, "l3c_err0");

    // CNT_W=2 saturation with 5 mismatches, then reset
    drv(1, 1, 0, 0, 0, 0);
    drv(1, 0, 1, 0, 1, 0);
    drv(1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drv(1, 0, 1, 0, 1, 1);
      mx();
    end
    ex(3, 2, 3, "sat_err"); ex(3, 1, 3, "sat_chk");
    ex(3, 3, 1, "sat_fail"); ex(3, 4, 0, "sat_pass");
    ex(0, 2, 5, "nosat_err");
    drv(0, 0, 1, 0, 0, 0);
    ex(3, 0, 0, "rst2_state"); ex(3, 1, 0, "rst2_chk");
    ex(3, 2, 0, "rst2_err");   ex(3, 3, 0, "rst2_fail");
    ex(3, 4, 0, "rst2_pass");  ex(3, 5, 0, "rst2_mis");
    drv(1, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    nchk++;
    if (mq.size() != 0 || sb.size() != 0) begin
      nfail++;
      $display("FAIL drain: got %0d/%0d pending want 0/0",
               mq.size(), sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/ff_resp_checker.md
FF_RESP_CHECKER -- requirements
Module: ff_resp_checker

Interface
REQ-001 The block SHALL have parameter LATENCY, default 1, meaning DUT clock-to-q latency in cycles (legal 1..8).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning width of the check and error counters.
REQ-003 The block SHALL have parameter STOP_ON_ERR, default 0, meaning that when 1, the first mismatch halts checking.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low block reset (0 = reset), sampled on the rising edge of clk.
REQ-006 Port en, input, 1: the checker is active while en=1.
REQ-007 Port clear, input, 1: synchronous counter/state clear, active-high.
REQ-008 Port dut_rst, input, 1: the DUT flop's reset as driven to it, active-high.
REQ-009 Port d_obs, input, 1: the DUT flop's d input as driven.
REQ-010 Port q_obs, input, 1: the DUT flop's q output as observed.
REQ-011 Port mismatch, output, 1: one-cycle pulse on a failed compare.
REQ-012 Port fail, output, 1: sticky, set on the first mismatch.
REQ-013 Port pass, output, 1: set while chk_cnt!=0 and fail=0.
REQ-014 Port chk_cnt, output, CNT_W: number of compares performed, saturating.
REQ-015 Port err_cnt, output, CNT_W: number of mismatches, saturating.
REQ-016 Port state, output, 2: FSM state; IDLE=0, FILL=1, CHECK=2, HALT=3.

Function
REQ-017 The block SHALL keep an expected-value shift pipeline of LATENCY stages, each stage holding a value bit and a valid bit.
REQ-018 Each cycle with en=1, stage 0 SHALL load value = (dut_rst ? 0 : d_obs) with valid=1, and stage k SHALL load stage k-1.
REQ-019 Each cycle with en=0, all valid bits SHALL clear and the values SHALL be don't-care.
REQ-020 A compare SHALL occur in any cycle where state=CHECK and the last stage is valid; it is q_obs versus the last-stage value.
REQ-021 On a compare, chk_cnt SHALL increment by 1 and hold at 2^CNT_W-1.
REQ-022 On a compare with q_obs != expected, the block SHALL register mismatch=1 for exactly the next cycle, increment err_cnt (saturating), and set fail.
REQ-023 FSM transitions SHALL be:
- IDLE->FILL when en=1.
- FILL->CHECK when the last-stage valid bit becomes 1, i.e. after LATENCY cycles of en=1.
- CHECK->HALT on a mismatch when STOP_ON_ERR=1.
- Any state->IDLE when en=0.
- HALT->IDLE only on clear or reset.
REQ-024 In HALT, the block SHALL perform no compares and SHALL hold both counters and fail.
REQ-025 Dropping en mid-check SHALL return the FSM to IDLE and invalidate the pipeline while holding the counters and fail; re-raising en SHALL re-enter FILL.
REQ-026 clear=1 SHALL zero both counters, fail and mismatch, invalidate the pipeline and force IDLE on the next edge; clear has priority over compare and over en.
REQ-027 If a compare and a saturated counter coincide, the counter SHALL hold its value while mismatch and fail still behave per REQ-022.
REQ-028 The pass output SHALL be combinational from chk_cnt and fail only.

Reset
REQ-029 With reset=0 at a rising edge, the block SHALL set state=IDLE, chk_cnt=0, err_cnt=0, mismatch=0, fail=0 (hence pass=0) and clear all valid bits.
REQ-030 reset has priority over clear and en.
REQ-031 Asserting reset mid-CHECK or in HALT SHALL abandon any in-flight compare without counting it.

Verification
REQ-032 Reset, then en=1 with LATENCY=1 and a correct DFF model driving d = 1,0,1,1 -> FILL for 1 cycle, then CHECK; after 4 compares chk_cnt=4, err_cnt=0, pass=1, mismatch never high.
REQ-033 With q_obs forced to 0 and d=1 for 3 cycles (STOP_ON_ERR=0) -> mismatch high on 3 consecutive cycles; err_cnt=3; fail=1; pass=0.
REQ-034 With STOP_ON_ERR=1 and a single injected mismatch -> state=HALT; err_cnt=1; later compares are ignored and chk_cnt is frozen; clear=1 -> IDLE with counters at 0.
REQ-035 With dut_rst=1 while d_obs=1 and q_obs=0 -> no mismatch (expected value 0); with dut_rst=1 and q_obs=1 -> mismatch.
REQ-036 With LATENCY=3: en=1 -> exactly 3 FILL cycles before the first compare; en dropped mid-CHECK -> IDLE with counters held; en re-raised -> 3 more FILL cycles.
REQ-037 With CNT_W=2, 5 mismatches -> err_cnt=3 (saturated), chk_cnt=3, fail=1; then reset=0 for one cycle -> all outputs zero and state=IDLE.
